// File: rtl/trigger_conditioner_if.sv
// -----------------------------------------------------------------------------
// trigger_conditioner_if
// Groups the trigger sources, configuration, control requests and status
// outputs of trigger_conditioner into one bundle. Clock and reset are not
// part of the bundle.
//   master : drives sources/config/requests, observes status (controller side)
//   slave  : the conditioner itself
// Signals:
//   I_trig_src    raw, already synchronised trigger sources
//   I_src_mask    1 = source participates in the combine
//   I_combine_and 0 = OR of enabled sources, 1 = AND of enabled sources
//   I_oneshot     1 = disarm after one pulse, 0 = re-arm automatically
//   I_delay       cycles from detected edge to pulse start
//   I_width       pulse length in cycles (0 behaves as 1)
//   I_arm         single-cycle arm request
//   I_abort       single-cycle abort request
//   O_trig_out    conditioned trigger pulse
//   O_armed       waiting for an edge
//   O_busy        delaying or pulsing
//   O_fire_count  pulses issued since last arm, saturating
//   O_missed      sticky: edge arrived while busy
//   O_heartbeat   heartbeat counter MSB
// -----------------------------------------------------------------------------
interface trigger_conditioner_if #(
    parameter int pNUM_SRC     = 4,
    parameter int pDELAY_WIDTH = 16,
    parameter int pPULSE_WIDTH = 16,
    parameter int pCOUNT_WIDTH = 16
);
    logic [pNUM_SRC-1:0]     I_trig_src;
    logic [pNUM_SRC-1:0]     I_src_mask;
    logic                    I_combine_and;
    logic                    I_oneshot;
    logic [pDELAY_WIDTH-1:0] I_delay;
    logic [pPULSE_WIDTH-1:0] I_width;
    logic                    I_arm;
    logic                    I_abort;
    logic                    O_trig_out;
    logic                    O_armed;
    logic                    O_busy;
    logic [pCOUNT_WIDTH-1:0] O_fire_count;
    logic                    O_missed;
    logic                    O_heartbeat;

    modport master (
        output I_trig_src, I_src_mask, I_combine_and, I_oneshot,
               I_delay, I_width, I_arm, I_abort,
        input  O_trig_out, O_armed, O_busy, O_fire_count, O_missed, O_heartbeat
    );

    modport slave (
        input  I_trig_src, I_src_mask, I_combine_and, I_oneshot,
               I_delay, I_width, I_arm, I_abort,
        output O_trig_out, O_armed, O_busy, O_fire_count, O_missed, O_heartbeat
    );
endinterface

// File: rtl/trigger_conditioner.sv
// -----------------------------------------------------------------------------
// trigger_conditioner
// Combines masked trigger sources (OR or AND), detects the rising edge of the
// combined level and, when armed, emits a delayed pulse of programmable width.
// Supports one-shot / continuous re-arm, abort, a saturating fire counter, a
// sticky missed-edge flag and a heartbeat that freezes while the pulse is out.
// Ports:
//   clk     single clock, all bundle inputs synchronous to it
//   resetn  asynchronous active-low reset
//   tc      trigger_conditioner_if slave (sources, config, requests, status)
// The interface instance must use the same width parameters as this module.
// -----------------------------------------------------------------------------
module trigger_conditioner #(
    parameter int pNUM_SRC        = 4,
    parameter int pDELAY_WIDTH    = 16,
    parameter int pPULSE_WIDTH    = 16,
    parameter int pCOUNT_WIDTH    = 16,
    parameter int pHEARTBEAT_BITS = 23
) (
    input  logic                 clk,
    input  logic                 resetn,
    trigger_conditioner_if.slave tc
);

    typedef enum logic [1:0] {IDLE, ARMED, DELAY, PULSE} state_t;

    state_t                     state;
    state_t                     state_nxt;
    logic                       comb;
    logic                       comb_q;
    logic                       edge_det;
    logic [pDELAY_WIDTH-1:0]    delay_cnt;
    logic [pPULSE_WIDTH-1:0]    width_cnt;
    logic [pPULSE_WIDTH-1:0]    width_eff;
    logic [pCOUNT_WIDTH-1:0]    fire_count;
    logic                       missed;
    logic [pHEARTBEAT_BITS-1:0] hb_cnt;
    logic                       pulse_last;
    logic                       trig_out;
    logic                       armed;
    logic                       busy;

    // An all-zero mask never fires, in either combine mode.
    function automatic logic combine_src(input logic [pNUM_SRC-1:0] src,
                                         input logic [pNUM_SRC-1:0] mask,
                                         input logic                and_mode);
        if (mask == '0)
            return 1'b0;
        if (and_mode)
            return &(src | ~mask);
        return |(src & mask);
    endfunction

    function automatic logic [pCOUNT_WIDTH-1:0] sat_inc(input logic [pCOUNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign comb       = combine_src(tc.I_trig_src, tc.I_src_mask, tc.I_combine_and);
    assign edge_det   = comb & ~comb_q;
    assign width_eff  = (tc.I_width == '0) ? {{(pPULSE_WIDTH-1){1'b0}}, 1'b1} : tc.I_width;
    assign pulse_last = (state == PULSE) && (width_cnt == {{(pPULSE_WIDTH-1){1'b0}}, 1'b1});

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic; abort overrides every other request
    always_comb begin
        state_nxt = state;
        if (tc.I_abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (tc.I_arm) state_nxt = ARMED;
                ARMED:   if (edge_det) state_nxt = (tc.I_delay == '0) ? PULSE : DELAY;
                DELAY:   if (delay_cnt == {{(pDELAY_WIDTH-1){1'b0}}, 1'b1}) state_nxt = PULSE;
                PULSE:   if (pulse_last) state_nxt = tc.I_oneshot ? IDLE : ARMED;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Outputs decoded from the registered state, so they are glitch-free
    always_comb begin
        trig_out = (state == PULSE);
        armed    = (state == ARMED);
        busy     = (state == DELAY) || (state == PULSE);
    end

    // Edge history, delay/width counters, fire counter, missed flag, heartbeat
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            comb_q     <= 1'b0;
            delay_cnt  <= '0;
            width_cnt  <= '0;
            fire_count <= '0;
            missed     <= 1'b0;
            hb_cnt     <= '0;
        end else begin
            comb_q <= comb;
            if (!trig_out)
                hb_cnt <= hb_cnt + 1'b1;
            if (!tc.I_abort) begin
                case (state)
                    IDLE: begin
                        if (tc.I_arm) begin
                            fire_count <= '0;
                            missed     <= 1'b0;
                        end
                    end
                    ARMED: begin
                        // Delay and width are captured only here; later changes
                        // on the config inputs do not affect this pulse.
                        if (edge_det) begin
                            delay_cnt <= tc.I_delay;
                            width_cnt <= width_eff;
                        end
                    end
                    DELAY: begin
                        delay_cnt <= delay_cnt - 1'b1;
                        if (edge_det)
                            missed <= 1'b1;
                    end
                    PULSE: begin
                        width_cnt <= width_cnt - 1'b1;
                        if (edge_det)
                            missed <= 1'b1;
                        if (pulse_last)
                            fire_count <= sat_inc(fire_count);
                    end
                    default: ;
                endcase
            end
        end
    end

    assign tc.O_trig_out   = trig_out;
    assign tc.O_armed      = armed;
    assign tc.O_busy       = busy;
    assign tc.O_fire_count = fire_count;
    assign tc.O_missed     = missed;
    assign tc.O_heartbeat  = hb_cnt[pHEARTBEAT_BITS-1];

endmodule

// File: tb/tb_trigger_conditioner.sv
// -----------------------------------------------------------------------------
// tb_trigger_conditioner
// Table of single-trigger vectors plus hand-written sequences for continuous
// mode, missed edges, abort, counter saturation, heartbeat and async reset.
// Expected pulses {start cycle, width} are queued when the triggering input is
// driven; a monitor records observed pulses, and the two queues are compared.
// The fire counter is built 8 bits wide and the heartbeat 4 bits wide so that
// saturation and heartbeat toggling are reached in a short run.
// -----------------------------------------------------------------------------
module tb_trigger_conditioner;

    localparam int NS = 4;
    localparam int DW = 16;
    localparam int PW = 16;
    localparam int CW = 8;
    localparam int HB = 4;

    typedef struct {
        int start;
        int width;
    } pulse_t;

    typedef struct {
        logic [NS-1:0] mask;
        logic          cand;
        logic [DW-1:0] dly;
        logic [PW-1:0] wid;
        logic [NS-1:0] pre;
        logic [NS-1:0] edg;
        logic          fire;
        string         name;
    } vec_t;

    logic clk;
    logic resetn;
    int   cyc;
    int   tests;
    int   fails;

    pulse_t exp_q[$];
    pulse_t obs_q[$];

    logic mon_prev;
    int   mon_st;

    trigger_conditioner_if #(.pNUM_SRC(NS), .pDELAY_WIDTH(DW),
                             .pPULSE_WIDTH(PW), .pCOUNT_WIDTH(CW)) bus ();

    trigger_conditioner #(
        .pNUM_SRC(NS), .pDELAY_WIDTH(DW), .pPULSE_WIDTH(PW),
        .pCOUNT_WIDTH(CW), .pHEARTBEAT_BITS(HB)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .tc     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor: a pulse seen high at samples s..s+w-1 is recorded as {s, w}
    initial begin
        mon_prev = 1'b0;
        mon_st   = 0;
        forever begin
            @(negedge clk);
            if (bus.O_trig_out && !mon_prev)
                mon_st = cyc;
            if (!bus.O_trig_out && mon_prev)
                obs_q.push_back('{start: mon_st, width: cyc - mon_st});
            mon_prev = bus.O_trig_out;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic push(input int s, input int w);
        exp_q.push_back('{start: s, width: w});
    endtask

    task automatic drain(input string name);
        pulse_t e;
        pulse_t o;
        chk({name, " pulse count"}, obs_q.size(), exp_q.size());
        while (exp_q.size() != 0 || obs_q.size() != 0) begin
            if (exp_q.size() != 0 && obs_q.size() != 0) begin
                e = exp_q.pop_front();
                o = obs_q.pop_front();
                chk({name, " start"}, o.start, e.start);
                chk({name, " width"}, o.width, e.width);
            end else if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk({name, " missing pulse start"}, -1, e.start);
            end else begin
                o = obs_q.pop_front();
                chk({name, " unexpected pulse start"}, o.start, -1);
            end
        end
    endtask

    task automatic chk_zero(input string name);
        chk({name, " trig_out"},   bus.O_trig_out,   0);
        chk({name, " armed"},      bus.O_armed,      0);
        chk({name, " busy"},       bus.O_busy,       0);
        chk({name, " fire_count"}, bus.O_fire_count, 0);
        chk({name, " missed"},     bus.O_missed,     0);
        chk({name, " heartbeat"},  bus.O_heartbeat,  0);
    endtask

    task automatic do_abort();
        bus.I_abort = 1'b1;
        step(1);
        bus.I_abort = 1'b0;
        step(1);
    endtask

    task automatic do_arm();
        bus.I_arm = 1'b1;
        step(1);
        bus.I_arm = 1'b0;
    endtask

    vec_t vecs[10];

    initial begin
        int e;
        int hb_prev;
        int toggles;
        vec_t v;

        vecs[0] = '{4'b0001, 1'b0, 16'd0, 16'd1, 4'b0000, 4'b0001, 1'b1, "or_d0_w1"};
        vecs[1] = '{4'b0001, 1'b0, 16'd5, 16'd3, 4'b0000, 4'b0001, 1'b1, "or_d5_w3"};
        vecs[2] = '{4'b0001, 1'b0, 16'd5, 16'd0, 4'b0000, 4'b0001, 1'b1, "or_d5_w0"};
        vecs[3] = '{4'b0101, 1'b1, 16'd2, 16'd2, 4'b0001, 4'b0101, 1'b1, "and_src2_rise"};
        vecs[4] = '{4'b0101, 1'b1, 16'd2, 16'd2, 4'b0000, 4'b0010, 1'b0, "and_src1_alone"};
        vecs[5] = '{4'b0000, 1'b0, 16'd0, 16'd1, 4'b0000, 4'b1111, 1'b0, "or_mask0"};
        vecs[6] = '{4'b0000, 1'b1, 16'd0, 16'd1, 4'b0000, 4'b1111, 1'b0, "and_mask0"};
        vecs[7] = '{4'b0001, 1'b0, 16'd0, 16'd1, 4'b0001, 4'b0001, 1'b0, "held_across_arm"};
        vecs[8] = '{4'b1010, 1'b0, 16'd1, 16'd4, 4'b0000, 4'b1000, 1'b1, "or_src3_d1_w4"};
        vecs[9] = '{4'b0110, 1'b1, 16'd3, 16'd2, 4'b0010, 4'b0110, 1'b1, "and_src12_d3_w2"};

        tests = 0;
        fails = 0;
        resetn            = 1'b0;
        bus.I_trig_src    = '0;
        bus.I_src_mask    = '0;
        bus.I_combine_and = 1'b0;
        bus.I_oneshot     = 1'b1;
        bus.I_delay       = '0;
        bus.I_width       = '0;
        bus.I_arm         = 1'b0;
        bus.I_abort       = 1'b0;

        step(2);
        chk_zero("reset");
        resetn = 1'b1;

        // Heartbeat toggles every 8 idle cycles with a 4-bit counter
        hb_prev = bus.O_heartbeat;
        toggles = 0;
        for (int k = 0; k < 32; k++) begin
            step(1);
            if (bus.O_heartbeat != hb_prev) toggles++;
            hb_prev = bus.O_heartbeat;
        end
        chk("hb idle toggles", toggles, 4);

        // Table-driven single-trigger vectors (one-shot)
        for (int i = 0; i < 10; i++) begin
            v = vecs[i];
            bus.I_src_mask    = v.mask;
            bus.I_combine_and = v.cand;
            bus.I_delay       = v.dly;
            bus.I_width       = v.wid;
            bus.I_oneshot     = 1'b1;
            bus.I_trig_src    = v.pre;
            step(3);
            do_arm();
            bus.I_trig_src = v.edg;
            e = cyc;
            if (v.fire)
                push(e + 1 + int'(v.dly), (v.wid == '0) ? 1 : int'(v.wid));
            step(int'(v.dly) + int'(v.wid) + 4);
            bus.I_trig_src = '0;
            step(2);
            drain(v.name);
            chk({v.name, " fire_count"}, bus.O_fire_count, v.fire ? 1 : 0);
            chk({v.name, " armed"},      bus.O_armed,      v.fire ? 0 : 1);
            chk({v.name, " busy"},       bus.O_busy,       0);
            if (!v.fire) do_abort();
        end

        // Continuous mode, missed edge, level hold, arm ignored while armed
        bus.I_src_mask = 4'b0001; bus.I_combine_and = 1'b0;
        bus.I_delay = 16'd10; bus.I_width = 16'd2; bus.I_oneshot = 1'b0;
        bus.I_trig_src = '0;
        step(2);
        do_arm();
        bus.I_trig_src = 4'b0001;
        e = cyc;
        push(e + 11, 2);
        step(2);
        bus.I_trig_src = '0;
        step(2);
        bus.I_trig_src = 4'b0001;
        step(12);
        chk("cont armed after pulse", bus.O_armed, 1);
        chk("cont missed", bus.O_missed, 1);
        chk("cont count 1", bus.O_fire_count, 1);
        bus.I_trig_src = '0;
        bus.I_arm = 1'b1;
        step(1);
        bus.I_arm = 1'b0;
        bus.I_trig_src = 4'b0001;
        e = cyc;
        push(e + 11, 2);
        step(20);
        drain("cont");
        chk("cont count 2", bus.O_fire_count, 2);
        chk("cont missed kept", bus.O_missed, 1);
        chk("cont armed", bus.O_armed, 1);
        do_abort();
        chk("cont abort armed", bus.O_armed, 0);
        bus.I_trig_src = '0;
        bus.I_oneshot = 1'b1;

        // Abort during PULSE truncates and does not count
        bus.I_delay = 16'd0; bus.I_width = 16'd5;
        step(2);
        do_arm();
        bus.I_trig_src = 4'b0001;
        e = cyc;
        push(e + 1, 2);
        step(2);
        bus.I_abort = 1'b1;
        step(1);
        bus.I_abort = 1'b0;
        chk("abort trig_out", bus.O_trig_out, 0);
        chk("abort count", bus.O_fire_count, 0);
        chk("abort armed", bus.O_armed, 0);
        bus.I_trig_src = '0;
        step(3);
        drain("abort_pulse");

        // Abort + arm together in IDLE stays IDLE
        bus.I_arm = 1'b1; bus.I_abort = 1'b1;
        step(1);
        bus.I_arm = 1'b0; bus.I_abort = 1'b0;
        step(1);
        chk("abort+arm armed", bus.O_armed, 0);

        // Abort + edge together in ARMED: no pulse
        do_arm();
        bus.I_trig_src = 4'b0001;
        bus.I_abort = 1'b1;
        step(1);
        bus.I_abort = 1'b0;
        step(2);
        chk("abort+edge armed", bus.O_armed, 0);
        chk("abort+edge busy", bus.O_busy, 0);
        bus.I_trig_src = '0;
        step(2);
        drain("abort_edge");

        // Heartbeat frozen during a long pulse
        bus.I_delay = 16'd0; bus.I_width = 16'd20;
        step(2);
        do_arm();
        bus.I_trig_src = 4'b0001;
        e = cyc;
        push(e + 1, 20);
        step(1);
        hb_prev = bus.O_heartbeat;
        toggles = 0;
        for (int k = 0; k < 20; k++) begin
            if (bus.O_heartbeat != hb_prev) toggles++;
            step(1);
        end
        chk("hb frozen changes", toggles, 0);
        bus.I_trig_src = '0;
        step(3);
        drain("hb_pulse");

        // Saturating fire count; each edge lands on the first ARMED cycle
        bus.I_oneshot = 1'b0; bus.I_delay = 16'd0; bus.I_width = 16'd1;
        step(2);
        do_arm();
        for (int i = 0; i < (1 << CW) + 3; i++) begin
            bus.I_trig_src = 4'b0001;
            push(cyc + 1, 1);
            step(1);
            bus.I_trig_src = '0;
            step(1);
        end
        step(3);
        chk("sat count", bus.O_fire_count, (1 << CW) - 1);
        drain("sat");
        do_abort();
        bus.I_oneshot = 1'b1;

        // Async reset mid-DELAY
        bus.I_delay = 16'd20; bus.I_width = 16'd2;
        step(2);
        do_arm();
        bus.I_trig_src = 4'b0001;
        step(2);
        bus.I_trig_src = '0;
        step(2);
        bus.I_trig_src = 4'b0001;
        step(2);
        chk("pre-reset busy", bus.O_busy, 1);
        chk("pre-reset missed", bus.O_missed, 1);
        #2;
        resetn = 1'b0;
        #1;
        chk_zero("async reset");
        step(1);
        resetn = 1'b1;
        bus.I_trig_src = '0;
        step(3);
        chk("post-reset armed", bus.O_armed, 0);
        drain("async_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
